// File: rtl/sdram_loader_pkg.sv
// Shared definitions for the SDRAM block loader and the dual-read buffer it fills.
package sdram_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } loader_state_t;

  localparam int MAX_OUTSTANDING_DEFAULT = 4;
  localparam int BUF_DEPTH               = 512;

endpackage

// File: rtl/sdram_loader_inflight.sv
// Up/down count of SDRAM reads issued but not yet returned.
// A simultaneous issue and return leaves the count unchanged.
module sdram_loader_inflight #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          dec_ok;

  // A return with nothing in flight cannot be ours, so it never underflows the count.
  assign dec_ok = dec && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (clr)
      count_next = '0;
    else if (inc && !dec_ok)
      count_next = count_reg + CW'(1);
    else if (dec_ok && !inc)
      count_next = count_reg - CW'(1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

  assign full  = (count_reg == CW'(MAX_OUTSTANDING));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/sdram_block_loader.sv
// Streams a contiguous block of SDRAM words into the weight/input buffer,
// keeping several reads in flight and writing returns in issue order.
module sdram_block_loader
  import sdram_loader_pkg::*;
#(
  parameter int SDRAM_AW        = 22,
  parameter int BUF_AW          = $clog2(BUF_DEPTH),
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                start,
  input  logic [SDRAM_AW-1:0] base_addr,
  input  logic [BUF_AW:0]     length,
  output logic                busy,
  output logic                done,
  output logic                rd_req,
  output logic [SDRAM_AW-1:0] rd_addr,
  input  logic                rd_ack,
  input  logic                rd_data_valid,
  input  logic [15:0]         rd_data,
  output logic                WR,
  output logic [BUF_AW-1:0]   wr_address_word,
  output logic [15:0]         wr_data_word
);

  localparam int              LW      = BUF_AW + 1;
  localparam logic [LW-1:0]   LEN_MAX = LW'(2 ** BUF_AW);

  loader_state_t       state_reg, state_next;
  logic [SDRAM_AW-1:0] base_reg;
  logic [LW-1:0]       len_reg;
  logic [LW-1:0]       issue_cnt_reg;
  logic [LW-1:0]       recv_cnt_reg;
  logic                wr_reg;
  logic [BUF_AW-1:0]   wr_addr_reg;
  logic [15:0]         wr_data_reg;

  logic accept, issue, take, win_full, win_empty, active;

  assign accept = (state_reg == ST_IDLE) && start;
  assign active = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);

  // Request depends only on registered state, so it stays put until acknowledged.
  assign rd_req  = (state_reg == ST_FETCH) && (issue_cnt_reg < len_reg) && !win_full;
  assign rd_addr = (state_reg == ST_FETCH) ? base_reg + SDRAM_AW'(issue_cnt_reg) : '0;
  assign issue   = rd_req && rd_ack;
  assign take    = rd_data_valid && active && !win_empty;

  assign busy            = (state_reg != ST_IDLE);
  assign done            = (state_reg == ST_DONE);
  assign WR              = wr_reg;
  assign wr_address_word = wr_addr_reg;
  assign wr_data_word    = wr_data_reg;

  sdram_loader_inflight #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_inflight (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .clr      (accept),
    .inc      (issue),
    .dec      (take),
    .full     (win_full),
    .empty    (win_empty)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = (length == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: if (issue && (issue_cnt_reg + LW'(1) == len_reg)) state_next = ST_DRAIN;
      // recv_cnt reaches len on the same edge that registers the final WR.
      ST_DRAIN: if (recv_cnt_reg == len_reg) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_reg     <= ST_IDLE;
      base_reg      <= '0;
      len_reg       <= '0;
      issue_cnt_reg <= '0;
      recv_cnt_reg  <= '0;
      wr_reg        <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      state_reg <= state_next;
      wr_reg    <= take;
      if (accept) begin
        base_reg      <= base_addr;
        len_reg       <= (length > LEN_MAX) ? LEN_MAX : length;
        issue_cnt_reg <= '0;
        recv_cnt_reg  <= '0;
      end else begin
        if (issue) issue_cnt_reg <= issue_cnt_reg + LW'(1);
        if (take)  recv_cnt_reg  <= recv_cnt_reg + LW'(1);
      end
      if (take) begin
        wr_addr_reg <= recv_cnt_reg[BUF_AW-1:0];
        wr_data_reg <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_sdram_block_loader.sv
// Directed bench for sdram_block_loader: an SDRAM responder with configurable
// ack pattern and return latency, plus a write monitor checked after each load.
module tb_sdram_block_loader;

  localparam int AW = 22;

  logic          CLOCK_50 = 1'b0;
  logic          RESET_N;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [9:0]    length;
  logic          busy, done, rd_req, rd_ack, rd_data_valid, WR;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data, wr_data_word;
  logic [8:0]    wr_address_word;

  sdram_block_loader dut (
    .CLOCK_50        (CLOCK_50),
    .RESET_N         (RESET_N),
    .start           (start),
    .base_addr       (base_addr),
    .length          (length),
    .busy            (busy),
    .done            (done),
    .rd_req          (rd_req),
    .rd_addr         (rd_addr),
    .rd_ack          (rd_ack),
    .rd_data_valid   (rd_data_valid),
    .rd_data         (rd_data),
    .WR              (WR),
    .wr_address_word (wr_address_word),
    .wr_data_word    (wr_data_word)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Responder configuration, written by the main sequence only.
  int ack_mode   = 0;
  int ret_lat    = 2;
  bit spur_valid = 1'b0;

  // Monitor state, written by the responder/monitor process only.
  int            cyc = 0;
  int            ld_iss = 0, ld_wr = 0, max_infl = 0, done_n = 0;
  int            addr_err = 0, waddr_err = 0, wdata_err = 0, dup_err = 0, hold_err = 0;
  logic [AW-1:0] ld_base = '0;
  logic [AW-1:0] iss_addr [0:1023];
  bit            written [0:511];
  logic [8:0]    last_wr_addr = '0;
  logic [AW-1:0] q_addr [$];
  int            q_rdy [$];
  bit            hold_pend = 1'b0;
  logic [AW-1:0] hold_addr = '0;

  int checks = 0;
  int failures = 0;

  function automatic logic [15:0] word_of(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A3C ^ {a[21:16], 10'h0};
  endfunction

  // SDRAM model and write monitor, both acting on the falling edge.
  initial begin
    rd_ack = 1'b0; rd_data_valid = 1'b0; rd_data = '0;
    forever begin
      @(negedge CLOCK_50);
      cyc++;
      if (!RESET_N) begin
        q_addr.delete(); q_rdy.delete();
        rd_ack = 1'b0; rd_data_valid = 1'b0; hold_pend = 1'b0;
      end else begin
        if (start && !busy) begin
          ld_base = base_addr; ld_iss = 0; ld_wr = 0; max_infl = 0;
          for (int i = 0; i < 512; i++) written[i] = 1'b0;
        end
        if (hold_pend && (!rd_req || rd_addr !== hold_addr)) hold_err++;
        rd_data_valid = spur_valid; rd_data = 16'hDEAD;
        if (q_rdy.size() > 0 && q_rdy[0] <= cyc) begin
          rd_data_valid = 1'b1;
          rd_data = word_of(q_addr[0]);
          void'(q_addr.pop_front()); void'(q_rdy.pop_front());
        end
        rd_ack = (ack_mode == 0) ? 1'b1 : (cyc % 4 == 0);
        hold_pend = rd_req && !rd_ack;
        hold_addr = rd_addr;
        if (rd_req && rd_ack) begin
          if (ld_iss < 1024) iss_addr[ld_iss] = rd_addr;
          if (rd_addr !== AW'(ld_base + AW'(ld_iss))) addr_err++;
          ld_iss++;
          q_addr.push_back(rd_addr); q_rdy.push_back(cyc + ret_lat);
          if (q_addr.size() > max_infl) max_infl = q_addr.size();
        end
      end
      if (WR) begin
        if (wr_address_word !== 9'(ld_wr)) waddr_err++;
        if (wr_data_word !== word_of(AW'(ld_base + AW'(wr_address_word)))) wdata_err++;
        if (written[wr_address_word]) dup_err++;
        written[wr_address_word] = 1'b1;
        last_wr_addr = wr_address_word;
        ld_wr++;
      end
      if (done) done_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #2;
  endtask

  // One block load; n = expected word count, exp_wait = expected cycles to done (-1: unchecked).
  task automatic load(input logic [AW-1:0] b, input logic [9:0] l, input int n,
                      input int ackm, input int lat, input bit poke, input int exp_wait);
    int e0, d0, w;
    bit wr_prev;
    ack_mode = ackm; ret_lat = lat;
    e0 = addr_err + waddr_err + wdata_err + dup_err + hold_err;
    d0 = done_n;
    base_addr = b; length = l; start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("rd_req_first", rd_req, n > 0);
    w = 0; wr_prev = 1'b0;
    while (!done && w < 3000) begin
      wr_prev = WR;
      step();
      w++;
      if (poke && w == 2) begin
        start = 1'b1; base_addr = 22'h2AAAAA; length = 10'd5;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    if (exp_wait >= 0) chk("cycles_to_done", w, exp_wait);
    chk("issue_count", ld_iss, n);
    chk("write_count", ld_wr, n);
    chk("monitor_errors", addr_err + waddr_err + wdata_err + dup_err + hold_err - e0, 0);
    chk("window_le_max", max_infl <= 4, 1);
    if (n > 0) begin
      chk("wr_before_done", wr_prev, 1);
      chk("last_wr_addr", last_wr_addr, n - 1);
    end
    chk("no_wr_at_done", WR, 0);
    $display("load base=%06h len=%0d issues=%0d writes=%0d cycles=%0d max_inflight=%0d",
             b, l, ld_iss, ld_wr, w, max_infl);
    step();
    chk("busy_low_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("done_pulses", done_n - d0, 1);
  endtask

  initial begin
    bit wr_any;
    int w;
    RESET_N = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    repeat (3) step();
    chk("rst_rd_req", rd_req, 0);
    chk("rst_wr", WR, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_address_word, 0);
    chk("rst_wr_data", wr_data_word, 0);
    RESET_N = 1'b1;
    step();

    // Returns arriving while idle must not produce writes.
    spur_valid = 1'b1;
    wr_any = 1'b0;
    repeat (2) begin step(); wr_any |= WR; end
    spur_valid = 1'b0;
    step(); wr_any |= WR;
    chk("spurious_idle_no_wr", wr_any, 0);
    $display("spurious rd_data_valid in idle wr_seen=%0d", wr_any);

    load(22'h000100, 10'd8, 8, 0, 2, 1'b0, -1);
    load(22'h000300, 10'd8, 8, 0, 1, 1'b0, 10);
    load(22'h000200, 10'd16, 16, 1, 2, 1'b1, -1);
    load(22'h020000, 10'd20, 20, 0, 10, 1'b0, -1);
    chk("window_reaches_4", max_infl, 4);
    load(22'h030000, 10'd20, 20, 0, 4, 1'b0, -1);
    chk("window_steady_4", max_infl, 4);
    load(22'h000500, 10'd0, 0, 0, 2, 1'b0, 0);
    load(22'h100000, 10'd600, 512, 0, 2, 1'b0, -1);
    load(22'h3FFFFE, 10'd4, 4, 0, 3, 1'b0, -1);
    chk("wrap_addr0", iss_addr[0], 22'h3FFFFE);
    chk("wrap_addr1", iss_addr[1], 22'h3FFFFF);
    chk("wrap_addr2", iss_addr[2], 22'h000000);
    chk("wrap_addr3", iss_addr[3], 22'h000001);

    // Reset in the middle of a 12-word load.
    ack_mode = 0; ret_lat = 2;
    base_addr = 22'h001000; length = 10'd12; start = 1'b1;
    step();
    start = 1'b0;
    w = 0;
    while (ld_wr < 5 && w < 200) begin step(); w++; end
    chk("mid_words_written", ld_wr, 5);
    RESET_N = 1'b0;
    step();
    chk("midrst_rd_req", rd_req, 0);
    chk("midrst_wr", WR, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    chk("midrst_wr_addr", wr_address_word, 0);
    chk("midrst_wr_data", wr_data_word, 0);
    $display("reset mid-transfer after %0d words", ld_wr);
    step();
    RESET_N = 1'b1;
    step();
    load(22'h000040, 10'd3, 3, 0, 2, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_block_loader.md
# sdram_block_loader

Fetches a contiguous block of 16-bit words from the SDRAM controller and writes them, in order, into the 512×16 dual-read weight/input buffer through its word write port (WR, wr_address_word, wr_data_word). It sits directly upstream of that buffer. It is started by the layer sequencer and signals completion so byte-wise reads can begin. It keeps up to four SDRAM reads in flight to hide controller latency.

## Interface
Parameters:
- SDRAM_AW, 22, SDRAM word-address width
- BUF_AW, 9, buffer word-address width (depth 2**BUF_AW = 512)
- MAX_OUTSTANDING, 4, maximum issued-but-unreturned reads (power of two, ≤ 8)

Ports:
- CLOCK_50  in  1  sole clock, all logic on rising edge
- RESET_N  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to load a block; sampled only in IDLE
- base_addr  in  SDRAM_AW  first SDRAM word address, captured on accepted start
- length  in  BUF_AW+1  words to load, captured on accepted start; 0 → no transfer; >512 clamped to 512
- busy  out  1  high from the cycle after accepted start through the DONE cycle
- done  out  1  one-cycle pulse, the cycle after the last WR
- rd_req  out  1  SDRAM read request, held until rd_ack
- rd_addr  out  SDRAM_AW  SDRAM word address for rd_req
- rd_ack  in  1  controller accepted the request this cycle (rd_req && rd_ack = issue)
- rd_data_valid  in  1  one returned word this cycle, strictly in issue order
- rd_data  in  16  returned word
- WR  out  1  buffer write strobe
- wr_address_word  out  BUF_AW  buffer word address
- wr_data_word  out  16  buffer write data

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: start=1 captures base_addr and clamped length, clears issue_cnt, recv_cnt, and outstanding. Length 0 → DONE. Otherwise → FETCH.
- FETCH: rd_req = (issue_cnt < len) && (outstanding < MAX_OUTSTANDING). rd_addr = base + issue_cnt. Each issue increments issue_cnt.
  - When issue_cnt reaches len → DRAIN.
  - rd_req and rd_addr stay stable while rd_req=1 and rd_ack=0.
- DRAIN: no requests. Wait until recv_cnt = len and the final WR has been registered → DONE.
- Outstanding counter: +1 on issue, −1 on rd_data_valid, both the same cycle → unchanged.
- Each rd_data_valid in FETCH/DRAIN with outstanding > 0: register WR=1, wr_address_word = recv_cnt[BUF_AW-1:0], wr_data_word = rd_data. recv_cnt increments.
- rd_data_valid in IDLE/DONE, or with outstanding = 0: ignored, no WR.
- DONE: done=1 for one cycle → IDLE. A start during DONE is ignored.
- start while busy: ignored.
- Addresses: rd_addr wraps modulo 2**SDRAM_AW. Buffer address never wraps, since len ≤ 512.
- Reset, including mid-transfer: state IDLE, all counters 0, and rd_req, WR, busy, done, rd_addr, wr_address_word, wr_data_word = 0. The SDRAM controller is reset by the same RESET_N, so no stale returns are expected.

## Timing
- start accepted at edge N → busy=1 and first rd_req=1 visible after edge N (cycle N+1).
- Issue throughput: 1 request/cycle while rd_ack=1 and the in-flight window is not full.
- rd_data_valid at edge M → WR=1 after edge M (one-cycle registered latency); WR is never combinational from inputs.
- Last WR at cycle K → done=1 at cycle K+1, busy falls at cycle K+2.
- length=0: busy=1 and done=1 in the same single cycle after start.
- Minimum transfer of L words with zero-latency ack and 1-cycle return: about L+3 cycles start→done.

## Structure
- Shared package sdram_loader_pkg holds:
  - the state encoding (ST_IDLE, ST_FETCH, ST_DRAIN, ST_DONE)
  - MAX_OUTSTANDING default
  - buffer depth constant 512, shared with the dual-read buffer
- One sub-module is natural: sdram_loader_inflight, the outstanding up/down counter with a full flag, clear, and simultaneous inc/dec.
- Everything else stays in one module.

## Test plan
- Basic load: base=0x000100, length=8, rd_ack always 1, returns 2 cycles after issue → rd_addr 0x100..0x107 once each; WR at addresses 0..7 carrying rd_data in order; one done pulse the cycle after the 8th WR.
- Backpressure: length=16, rd_ack low for 3 of every 4 cycles → rd_req/rd_addr held stable while unacked; all 16 words written at 0..15; no duplicate addresses.
- Window limit: length=20, returns delayed 10 cycles → never more than 4 issues without a return; issue stalls at outstanding=4; simultaneous issue+return keeps outstanding constant.
- Edges: length=0 → no rd_req, done one cycle after start. length=600 → exactly 512 requests, last WR at address 511. base=0x3FFFFE, length=4 → rd_addr 0x3FFFFE, 0x3FFFFF, 0x000000, 0x000001.
- Spurious/ignored inputs: rd_data_valid in IDLE → no WR. start pulses during FETCH → ignored, counts unchanged.
- Reset mid-transfer: RESET_N=0 after 5 of 12 words → next cycle all outputs 0, state IDLE. A new start with length=3 then completes normally at addresses 0..2.
